trig_sched: RTL and testbench
=============================

# trig_sched

Trigger-request scheduler that sits in front of the ALCT trigger pipeline. It arbitrates between external-trigger requests and test-pulse injection requests, issues the FEB inject strobe, opens a fixed observation window on the best-track outputs (hv/hnp/hp), and captures the first valid track as a result record. After each window it holds the pipeline in a dead-time state via trig_stop. Requests that cannot be served are queued one deep (inject only) or counted as lost.

## Interface
- INJ_DLY, 4: cycles from inject strobe to window open; legal range 1..15.
- WIN_LEN, 8: window length in cycles; legal range 1..15.
- DEAD_T, 16: dead-time length in cycles; legal range 1..63.
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- ext_trig_en  in  1  enables ext_trig_req; when 0 the request is ignored and not counted.
- ext_trig_req  in  1  single-cycle external trigger request.
- inject_en  in  1  enables inj_req; when 0 the request is ignored and not counted.
- inj_req  in  1  single-cycle injection request.
- hv  in  1  best-track valid from the pipeline.
- hnp  in  7  best-track key wire.
- hp  in  2  best-track quality.
- cnt_clr  in  1  synchronous clear of lost_cnt.
- inject  out  1  one-cycle FEB inject strobe.
- win_open  out  1  high while the observation window is open.
- trig_stop  out  1  high during dead time.
- res_valid  out  1  one-cycle result strobe.
- res_hit  out  1  a track was seen in the window.
- res_key  out  7  captured hnp, or 0 if no hit.
- res_q  out  2  captured hp, or 0 if no hit.
- res_src  out  1  request source: 0 = external, 1 = inject.
- inj_pend  out  1  an injection request is queued.
- lost_cnt  out  8  count of dropped requests; saturates at 255.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - INJ_WAIT: INJ_DLY cycles.
  - WINDOW: WIN_LEN cycles.
  - DEAD: DEAD_T cycles, then back to IDLE.
- Arbitration in IDLE:
  - An enabled ext_trig_req goes to WINDOW with src=0.
  - Otherwise, an enabled inj_req or inj_pend goes to INJ_WAIT with src=1, pulses inject, and clears inj_pend.
  - External has priority. If ext and inj arrive together, the inject is latched into inj_pend.
- Requests outside IDLE:
  - An enabled ext_trig_req is dropped and lost_cnt is incremented.
  - An enabled inj_req sets inj_pend if it is clear; if inj_pend is already set, the request is dropped and lost_cnt is incremented.
  - Two drops in the same cycle increment lost_cnt by 2, still saturating at 255.
- WINDOW capture:
  - The first cycle with hv=1 latches hnp and hp and sets the hit flag.
  - Later hv pulses are ignored.
  - The window always runs its full length.
- Result: on entry to DEAD, res_valid pulses for one cycle. res_* hold their value until the next result.
- cnt_clr has priority over an increment in the same cycle.
- Reset:
  - Asynchronous; takes effect mid-operation.
  - Returns the FSM to IDLE and clears inj_pend.
  - All outputs go to 0, including res_* and lost_cnt.

## Timing
- All outputs are registered.
- ext_trig_req sampled in IDLE at cycle T:
  - win_open high for cycles T+1..T+WIN_LEN.
  - res_valid and trig_stop rise at T+WIN_LEN+1.
  - trig_stop stays high through T+WIN_LEN+DEAD_T.
  - FSM is in IDLE at T+WIN_LEN+DEAD_T+1, and a new request can be sampled in that cycle.
- inj_req sampled in IDLE at cycle T:
  - inject high at T+1 only.
  - INJ_WAIT spans T+1..T+INJ_DLY.
  - win_open high for T+INJ_DLY+1..T+INJ_DLY+WIN_LEN.
  - res_valid at T+INJ_DLY+WIN_LEN+1.
- A queued inject is served in the first IDLE cycle, with the same timing as an inj_req sampled there.
- hv is registered against the window: a track counts only if it is present in a cycle where win_open=1.

## Structure
- Package trig_sched_pkg holds:
  - the state enum (IDLE, INJ_WAIT, WINDOW, DEAD);
  - the SRC_EXT and SRC_INJ constants;
  - the width of the shared phase counter (6 bits, covering DEAD_T).
- A single phase counter is reloaded on every state entry.
- Sub-module sat_cnt8 implements the saturating lost counter: increment by 0/1/2, synchronous clear, asynchronous reset.

## Test plan
All scenarios use INJ_DLY=4, WIN_LEN=8, DEAD_T=16.
- ext_trig_req at T=10, hv=1 with hnp=0x2A, hp=3 at T=13 → win_open 11..18; res_valid at 19 with res_hit=1, res_key=0x2A, res_q=3, res_src=0; trig_stop 19..34.
- inj_req at T=10 with no hv → inject at 11; win_open 15..22; res_valid at 23 with res_hit=0, res_key=0, res_src=1.
- ext_trig_req and inj_req both at T=10 → external served first; inj_pend=1 from 11; inject at 36; inj_pend=0 from 36.
- During DEAD: 3 inj_req then 2 ext_trig_req → inj_pend=1, lost_cnt=4; cnt_clr → lost_cnt=0; 300 dropped requests → lost_cnt=255.
- Two hv pulses in the window (keys 0x05, then 0x40) → res_key=0x05. An hv at the cycle right after the window closes → res_hit=0.
- rst_n low during WINDOW → all outputs 0 immediately; after release, the FSM is in IDLE and an ext_trig_req is served with nominal timing.

Source files
------------

// File: rtl/trig_sched_pkg.sv
// Shared types and constants for the trigger-request scheduler.
package trig_sched_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        INJ_WAIT = 2'd1,
        WINDOW   = 2'd2,
        DEAD     = 2'd3
    } state_t;

    localparam logic SRC_EXT = 1'b0;
    localparam logic SRC_INJ = 1'b1;

    localparam int PH_W   = 6;
    localparam int LOST_W = 8;

endpackage

// File: rtl/sat_cnt8.sv
// Saturating drop counter: adds 0/1/2 per cycle, synchronous clear wins over increment.
module sat_cnt8
    import trig_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic [1:0]        inc,
    output logic [LOST_W-1:0] cnt
);

    logic [LOST_W:0] sum;

    always_comb begin
        sum = {1'b0, cnt} + {{(LOST_W-1){1'b0}}, inc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (sum[LOST_W]) begin
            cnt <= '1;
        end else begin
            cnt <= sum[LOST_W-1:0];
        end
    end

endmodule

// File: rtl/trig_sched.sv
// Arbitrates external-trigger and test-pulse requests, runs the observation
// window on the best-track outputs and holds the pipeline in dead time.
module trig_sched
    import trig_sched_pkg::*;
#(
    parameter int INJ_DLY = 4,
    parameter int WIN_LEN = 8,
    parameter int DEAD_T  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ext_trig_en,
    input  logic              ext_trig_req,
    input  logic              inject_en,
    input  logic              inj_req,
    input  logic              hv,
    input  logic [6:0]        hnp,
    input  logic [1:0]        hp,
    input  logic              cnt_clr,
    output logic              inject,
    output logic              win_open,
    output logic              trig_stop,
    output logic              res_valid,
    output logic              res_hit,
    output logic [6:0]        res_key,
    output logic [1:0]        res_q,
    output logic              res_src,
    output logic              inj_pend,
    output logic [LOST_W-1:0] lost_cnt
);

    state_t          state, state_nxt;
    logic [PH_W-1:0] ph, ph_nxt;
    logic            ph_done;
    logic            ext_v, inj_v;
    logic            pend_nxt, src, src_nxt, go_inj;
    logic            ext_drop, inj_drop, res_done;
    logic [1:0]      drop_inc;
    logic            cap_hit;
    logic [6:0]      cap_key;
    logic [1:0]      cap_q;

    always_comb begin
        ext_v     = ext_trig_en & ext_trig_req;
        inj_v     = inject_en & inj_req;
        ph_done   = (ph == '0);
        state_nxt = state;
        ph_nxt    = ph_done ? ph : ph - PH_W'(1);
        pend_nxt  = inj_pend;
        src_nxt   = src;
        go_inj    = 1'b0;
        ext_drop  = 1'b0;
        inj_drop  = 1'b0;

        case (state)
            IDLE: begin
                if (ext_v) begin
                    state_nxt = WINDOW;
                    ph_nxt    = PH_W'(WIN_LEN - 1);
                    src_nxt   = SRC_EXT;
                    if (inj_v) begin
                        if (inj_pend) inj_drop = 1'b1;
                        else          pend_nxt = 1'b1;
                    end
                end else if (inj_v || inj_pend) begin
                    // A fresh request coinciding with a queued one is served as one pulse.
                    state_nxt = INJ_WAIT;
                    ph_nxt    = PH_W'(INJ_DLY - 1);
                    src_nxt   = SRC_INJ;
                    pend_nxt  = 1'b0;
                    go_inj    = 1'b1;
                end
            end
            INJ_WAIT: if (ph_done) begin
                state_nxt = WINDOW;
                ph_nxt    = PH_W'(WIN_LEN - 1);
            end
            WINDOW: if (ph_done) begin
                state_nxt = DEAD;
                ph_nxt    = PH_W'(DEAD_T - 1);
            end
            DEAD: if (ph_done) begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (state != IDLE) begin
            ext_drop = ext_v;
            if (inj_v) begin
                if (inj_pend) inj_drop = 1'b1;
                else          pend_nxt = 1'b1;
            end
        end

        res_done = (state == WINDOW) && ph_done;
        drop_inc = {1'b0, ext_drop} + {1'b0, inj_drop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ph        <= '0;
            inj_pend  <= 1'b0;
            src       <= SRC_EXT;
            inject    <= 1'b0;
            win_open  <= 1'b0;
            trig_stop <= 1'b0;
            res_valid <= 1'b0;
            res_hit   <= 1'b0;
            res_key   <= '0;
            res_q     <= '0;
            res_src   <= 1'b0;
            cap_hit   <= 1'b0;
            cap_key   <= '0;
            cap_q     <= '0;
        end else begin
            state     <= state_nxt;
            ph        <= ph_nxt;
            inj_pend  <= pend_nxt;
            src       <= src_nxt;
            inject    <= go_inj;
            win_open  <= (state_nxt == WINDOW);
            trig_stop <= (state_nxt == DEAD);
            res_valid <= res_done;

            if (state != WINDOW && state_nxt == WINDOW) begin
                cap_hit <= 1'b0;
            end else if (state == WINDOW && hv && !cap_hit) begin
                cap_hit <= 1'b1;
                cap_key <= hnp;
                cap_q   <= hp;
            end

            // Result folds in a hit arriving on the window's last cycle.
            if (res_done) begin
                res_hit <= cap_hit | hv;
                res_key <= cap_hit ? cap_key : (hv ? hnp : 7'd0);
                res_q   <= cap_hit ? cap_q : (hv ? hp : 2'd0);
                res_src <= src;
            end
        end
    end

    sat_cnt8 u_lost (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (drop_inc),
        .cnt   (lost_cnt)
    );

endmodule

// File: tb/tb_trig_sched.sv
// Self-checking bench for trig_sched against an interval-based reference model.
module tb_trig_sched;

    localparam int ID = 4;
    localparam int WL = 8;
    localparam int DT = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ext_trig_en, ext_trig_req, inject_en, inj_req, hv, cnt_clr;
    logic [6:0] hnp;
    logic [1:0] hp;
    logic       inject, win_open, trig_stop, res_valid, res_hit, res_src, inj_pend;
    logic [6:0] res_key;
    logic [1:0] res_q;
    logic [7:0] lost_cnt;

    trig_sched #(.INJ_DLY(ID), .WIN_LEN(WL), .DEAD_T(DT)) dut (
        .clk(clk), .rst_n(rst_n),
        .ext_trig_en(ext_trig_en), .ext_trig_req(ext_trig_req),
        .inject_en(inject_en), .inj_req(inj_req),
        .hv(hv), .hnp(hnp), .hp(hp), .cnt_clr(cnt_clr),
        .inject(inject), .win_open(win_open), .trig_stop(trig_stop),
        .res_valid(res_valid), .res_hit(res_hit), .res_key(res_key),
        .res_q(res_q), .res_src(res_src), .inj_pend(inj_pend), .lost_cnt(lost_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int t;

    // Reference model: the schedule of each accepted request as cycle intervals.
    int         win_lo, win_hi, dead_hi, inj_at, free_at, m_lost;
    bit         m_pend, m_hit, m_src, r_hit, r_src;
    logic [6:0] m_key, r_key;
    logic [1:0] m_q, r_q;

    task automatic model_reset();
        win_lo = -1000; win_hi = -1000; dead_hi = -1000; inj_at = -1000;
        free_at = t; m_lost = 0; m_pend = 0; m_hit = 0; m_src = 0;
        m_key = 0; m_q = 0; r_hit = 0; r_key = 0; r_q = 0; r_src = 0;
    endtask

    task automatic model_step(input int c);
        bit ev, iv;
        int drops;
        ev = ext_trig_en && ext_trig_req;
        iv = inject_en && inj_req;
        drops = 0;
        if (c >= win_lo && c <= win_hi && hv && !m_hit) begin
            m_hit = 1; m_key = hnp; m_q = hp;
        end
        if (c == win_hi) begin
            r_hit = m_hit; r_key = m_hit ? m_key : 7'd0;
            r_q = m_hit ? m_q : 2'd0; r_src = m_src;
        end
        if (c >= free_at) begin
            if (ev) begin
                win_lo = c + 1; win_hi = c + WL; m_src = 0; m_hit = 0;
                if (iv) begin
                    if (m_pend) drops++;
                    else m_pend = 1;
                end
            end else if (iv || m_pend) begin
                inj_at = c + 1; win_lo = c + ID + 1; win_hi = c + ID + WL;
                m_src = 1; m_hit = 0; m_pend = 0;
            end
            dead_hi = win_hi + DT;
            free_at = (win_lo > c) ? dead_hi + 1 : c + 1;
        end else begin
            if (ev) drops++;
            if (iv) begin
                if (m_pend) drops++;
                else m_pend = 1;
            end
        end
        m_lost = (m_lost + drops > 255) ? 255 : m_lost + drops;
        if (cnt_clr) m_lost = 0;
    endtask

    function automatic logic [23:0] exp_vec(input int nt);
        return {nt == inj_at, (nt >= win_lo && nt <= win_hi), (nt > win_hi && nt <= dead_hi),
                nt == win_hi + 1, r_hit, r_key, r_q, r_src, m_pend, 8'(m_lost)};
    endfunction

    function automatic logic [23:0] act_vec();
        return {inject, win_open, trig_stop, res_valid, res_hit, res_key, res_q,
                res_src, inj_pend, lost_cnt};
    endfunction

    task automatic tick(output logic [23:0] e, output logic [23:0] a);
        @(posedge clk);
        model_step(t);
        t++;
        #1;
        e = exp_vec(t);
        a = act_vec();
    endtask

    task automatic quiet();
        ext_trig_en = 1; ext_trig_req = 0; inject_en = 1; inj_req = 0;
        hv = 0; hnp = 0; hp = 0; cnt_clr = 0;
    endtask

    task automatic settle();
        logic [23:0] e, a;
        quiet();
        for (int k = 0; k < 200 && (t < free_at || m_pend); k++) tick(e, a);
        tick(e, a);
    endtask

    task automatic test_reset();
        logic [23:0] e, a;
        quiet();
        #12;
        n_tests++;
        if (act_vec() !== 24'd0) begin
            n_fail++; $display("FAIL reset_outputs got=%h exp=000000", act_vec());
        end
        t = 0;
        model_reset();
        rst_n = 1;
        for (int r = 0; r < 3; r++) begin
            tick(e, a);
            n_tests++;
            if (a !== e) begin n_fail++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", t, a, e); end
        end
    endtask

    task automatic test_ext();
        logic [23:0] e, a;
        for (int r = 0; r <= 26; r++) begin
            quiet();
            ext_trig_req = (r == 0);
            hv = (r == 3); hnp = 7'h2A; hp = 2'd3;
            tick(e, a);
            n_tests++;
            if (a !== e) begin n_fail++; $display("FAIL ext_model rel=%0d got=%h exp=%h", r + 1, a, e); end
            if (r + 1 == 9) begin
                n_tests++;
                if ({res_valid, res_hit, res_key, res_q, res_src, trig_stop} !== {1'b1, 1'b1, 7'h2A, 2'd3, 1'b0, 1'b1}) begin
                    n_fail++; $display("FAIL ext_result got=%b%b %h %0d %b exp=11 2a 3 0", res_valid, res_hit, res_key, res_q, res_src);
                end
            end
            if (r + 1 == 24 || r + 1 == 25) begin
                n_tests++;
                if (trig_stop !== (r + 1 == 24)) begin
                    n_fail++; $display("FAIL ext_dead_edge rel=%0d got=%b exp=%b", r + 1, trig_stop, r + 1 == 24);
                end
            end
        end
        settle();
    endtask

    task automatic test_inj();
        logic [23:0] e, a;
        for (int r = 0; r <= 26; r++) begin
            quiet();
            inj_req = (r == 0);
            tick(e, a);
            n_tests++;
            if (a !== e) begin n_fail++; $display("FAIL inj_model rel=%0d got=%h exp=%h", r + 1, a, e); end
            if (r + 1 == 1 || r + 1 == 5 || r + 1 == 13) begin
                n_tests++;
                if ({inject, win_open, res_valid} !== {r + 1 == 1, r + 1 == 5, r + 1 == 13}) begin
                    n_fail++; $display("FAIL inj_timing rel=%0d got=%b%b%b", r + 1, inject, win_open, res_valid);
                end
            end
            if (r + 1 == 13) begin
                n_tests++;
                if ({res_hit, res_key, res_src} !== {1'b0, 7'd0, 1'b1}) begin
                    n_fail++; $display("FAIL inj_result got=%b %h %b exp=0 00 1", res_hit, res_key, res_src);
                end
            end
        end
        settle();
    endtask

    task automatic test_back_to_back();
        logic [23:0] e, a;
        for (int r = 0; r <= 28; r++) begin
            quiet();
            ext_trig_req = (r == 0);
            inj_req = (r == 0);
            tick(e, a);
            n_tests++;
            if (a !== e) begin n_fail++; $display("FAIL both_model rel=%0d got=%h exp=%h", r + 1, a, e); end
            if (r + 1 == 1 || r + 1 == 25 || r + 1 == 26) begin
                n_tests++;
                if ({inject, inj_pend} !== {r + 1 == 26, r + 1 != 26}) begin
                    n_fail++; $display("FAIL both_pend rel=%0d got=%b%b", r + 1, inject, inj_pend);
                end
            end
        end
        settle();
    endtask

    task automatic test_dead_drops();
        logic [23:0] e, a;
        for (int r = 0; r <= 17; r++) begin
            quiet();
            cnt_clr = (r == 0 || r == 15);
            ext_trig_req = (r == 0 || r == 13 || r == 14 || r == 15 || r == 16);
            ext_trig_en = (r != 16);
            inj_req = (r >= 10 && r <= 12);
            tick(e, a);
            n_tests++;
            if (a !== e) begin n_fail++; $display("FAIL drop_model rel=%0d got=%h exp=%h", r + 1, a, e); end
            if (r + 1 == 15) begin
                n_tests++;
                if ({inj_pend, lost_cnt} !== {1'b1, 8'd4}) begin
                    n_fail++; $display("FAIL drop_count got=%b %0d exp=1 4", inj_pend, lost_cnt);
                end
            end
            if (r + 1 == 17) begin
                n_tests++;
                if (lost_cnt !== 8'd0) begin n_fail++; $display("FAIL drop_clear got=%0d exp=0", lost_cnt); end
            end
        end
        settle();
    endtask

    task automatic test_saturation();
        logic [23:0] e, a;
        for (int r = 0; r < 200; r++) begin
            quiet();
            ext_trig_req = 1; inj_req = 1;
            tick(e, a);
            n_tests++;
            if (a !== e) begin n_fail++; $display("FAIL sat_model rel=%0d got=%h exp=%h", r + 1, a, e); end
        end
        n_tests++;
        if (lost_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_value got=%0d exp=255", lost_cnt); end
        settle();
        quiet(); cnt_clr = 1;
        tick(e, a);
        n_tests++;
        if (a !== e) begin n_fail++; $display("FAIL sat_clear got=%h exp=%h", a, e); end
    endtask

    task automatic test_capture();
        logic [23:0] e, a;
        for (int pass = 0; pass < 2; pass++) begin
            for (int r = 0; r <= 10; r++) begin
                quiet();
                ext_trig_req = (r == 0);
                if (pass == 0) begin
                    hv = (r == 2 || r == 5);
                    hnp = (r == 2) ? 7'h05 : 7'h40;
                    hp = (r == 2) ? 2'd1 : 2'd2;
                end else begin
                    hv = (r == 9); hnp = 7'h11; hp = 2'd2;
                end
                tick(e, a);
                n_tests++;
                if (a !== e) begin n_fail++; $display("FAIL cap_model p%0d rel=%0d got=%h exp=%h", pass, r + 1, a, e); end
                if (r + 1 == 10) begin
                    n_tests++;
                    if ({res_hit, res_key, res_q} !== ((pass == 0) ? {1'b1, 7'h05, 2'd1} : {1'b0, 7'h00, 2'd0})) begin
                        n_fail++; $display("FAIL cap_first p%0d got=%b %h %0d", pass, res_hit, res_key, res_q);
                    end
                end
            end
            settle();
        end
    endtask

    task automatic test_async_reset();
        logic [23:0] e, a;
        for (int r = 0; r < 4; r++) begin
            quiet();
            ext_trig_req = (r == 0);
            tick(e, a);
            n_tests++;
            if (a !== e) begin n_fail++; $display("FAIL arst_pre rel=%0d got=%h exp=%h", r + 1, a, e); end
        end
        #2 rst_n = 0;
        #1;
        n_tests++;
        if (act_vec() !== 24'd0) begin n_fail++; $display("FAIL arst_outputs got=%h exp=000000", act_vec()); end
        model_reset();
        #2 rst_n = 1;
        for (int r = 0; r <= 10; r++) begin
            quiet();
            ext_trig_req = (r == 0);
            tick(e, a);
            n_tests++;
            if (a !== e) begin n_fail++; $display("FAIL arst_post rel=%0d got=%h exp=%h", r + 1, a, e); end
            if (r + 1 == 1 || r + 1 == 9) begin
                n_tests++;
                if ({win_open, res_valid} !== {r + 1 == 1, r + 1 == 9}) begin
                    n_fail++; $display("FAIL arst_timing rel=%0d got=%b%b", r + 1, win_open, res_valid);
                end
            end
        end
        settle();
    endtask

    task automatic test_random();
        logic [23:0] e, a;
        for (int r = 0; r < 800; r++) begin
            ext_trig_en  = ($urandom_range(0, 3) != 0);
            ext_trig_req = ($urandom_range(0, 11) == 0);
            inject_en    = ($urandom_range(0, 3) != 0);
            inj_req      = ($urandom_range(0, 9) == 0);
            hv           = ($urandom_range(0, 3) == 0);
            hnp          = 7'($urandom);
            hp           = 2'($urandom);
            cnt_clr      = ($urandom_range(0, 63) == 0);
            tick(e, a);
            n_tests++;
            if (a !== e) begin n_fail++; $display("FAIL rand_model cyc=%0d got=%h exp=%h", t, a, e); end
        end
        settle();
    endtask

    initial begin
        t = 0;
        test_reset();
        test_ext();
        test_inj();
        test_back_to_back();
        test_dead_drops();
        test_saturation();
        test_capture();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
